rom_burst_arbiter: RTL

Shares one 32-entry synchronous-read ROM between up to four requesters. Each requester asks for a burst of consecutive addresses, and the block grants one requester at a time by round-robin. It then drives the ROM address and enable for the whole burst and returns the read data tagged with the requester ID. It sits between the ROM and its client blocks, and replaces free-running address counters as the single driver of the ROM address bus.

---
 rtl/rom_burst_arbiter_pkg.sv | 21 ++
 rtl/rom_burst_arbiter_if.sv | 38 +++
 rtl/rom_burst_arbiter_rr.sv | 59 +++++
 rtl/rom_burst_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rom_burst_arbiter_pkg.sv
// Shared types and constants for the ROM burst arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_arb_pkg;

  localparam int ADDR_W_DFLT = 5;
  localparam int DATA_W_DFLT = 8;
  localparam int ROM_DEPTH   = 2 ** ADDR_W_DFLT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Requester-index width; a single requester still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_burst_arbiter_if.sv
// Request, ROM and read-return signals of the ROM burst arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; requesters hold req until granted.
interface rom_burst_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int NREQ   = 2
);
  localparam int ID_W = id_w(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] start_addr;
  logic [NREQ*ADDR_W-1:0] len;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   rom_en;
  logic [ADDR_W-1:0]      rom_addr;
  logic [DATA_W-1:0]      rom_data;
  logic                   rd_valid;
  logic [DATA_W-1:0]      rd_data;
  logic [ID_W-1:0]        rd_id;
  logic                   done;

  // Arbiter side.
  modport master (
    input  req, start_addr, len, rom_data,
    output grant, busy, rom_en, rom_addr, rd_valid, rd_data, rd_id, done
  );

  // Requesters plus ROM side.
  modport slave (
    output req, start_addr, len, rom_data,
    input  grant, busy, rom_en, rom_addr, rd_valid, rd_data, rd_id, done
  );

endinterface

// File: rtl/rom_burst_arbiter_rr.sv
// Picks one requester: round-robin from ptr, or lowest index with ROM_ARB_FIXED_PRIO_EN.
// Latency: combinational.
// Backpressure: none; caller decides when the winner is taken.
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any_req
);

  logic found;

  assign any_req = |req;

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Fixed priority has no rotation, so the pointer is ignored.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Lowest-index requester always wins.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        found   = 1'b1;
        win[k]  = 1'b1;
        win_idx = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] idx;

  // Search upward from ptr with wrap; first set request wins.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one sync-read ROM among NREQ requesters, one burst at a time (ROM_ARB_FIXED_PRIO_EN: fixed priority).
// Latency: grant 1 cycle after req, first read 1 cycle after grant, data ROM_LAT cycles after each read.
// Backpressure: requests are held off while busy; no stall once a burst issues.
module rom_burst_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int NREQ    = 2,
  parameter int ROM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  rom_burst_arbiter_if.master bus
);

  localparam int ID_W = id_w(NREQ);

  typedef struct packed {
    logic            vld;
    logic            last;
    logic [ID_W-1:0] id;
  } ret_t;

  state_t            state;
  logic [NREQ-1:0]   grant_q;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] sel_start;
  logic [ADDR_W-1:0] sel_len;
  logic              rom_en_q;
  logic              rom_last;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win_idx;
  logic [NREQ-1:0]   win;
  logic              any_req;
  logic              take;
  logic              tail_done;
  ret_t              pipe [ROM_LAT];
  ret_t              tail;

  rom_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (bus.req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  // Pick the winner's start address and length out of the flat buses.
  always_comb begin
    sel_start = '0;
    sel_len   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        sel_start = bus.start_addr[i*ADDR_W +: ADDR_W];
        sel_len   = bus.len[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign tail      = pipe[ROM_LAT-1];
  assign tail_done = tail.vld & tail.last;

  // A new burst is accepted from a quiet IDLE, or on the done cycle so the
  // next grant can follow done back-to-back.
  assign take = any_req &
                (((state == IDLE) && (grant_q == '0)) ||
                 ((state == DRAIN) && tail_done));

`ifdef ROM_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_W-1:0] ptr_q;
  assign ptr = ptr_q;

  // Round-robin pointer moves just past the requester that was granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (take) begin
      ptr_q <= (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + ID_W'(1);
    end
  end
`endif

  // Burst sequencing: grant and latch, issue len+1 consecutive reads, drain the return pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      start_q    <= '0;
      len_q      <= '0;
      cnt        <= '0;
      owner      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_last   <= 1'b0;
    end else begin
      grant_q <= '0;
      if (take) begin
        grant_q <= win;
        start_q <= sel_start;
        len_q   <= sel_len;
        owner   <= win_idx;
      end
      case (state)
        IDLE: begin
          if (grant_q != '0) begin
            state      <= ISSUE;
            rom_en_q   <= 1'b1;
            rom_addr_q <= start_q;
            cnt        <= len_q;
            rom_last   <= (len_q == '0);
          end
        end
        ISSUE: begin
          if (cnt == '0) begin
            state    <= DRAIN;
            rom_en_q <= 1'b0;
            rom_last <= 1'b0;
          end else begin
            rom_addr_q <= rom_addr_q + ADDR_W'(1);
            cnt        <= cnt - ADDR_W'(1);
            rom_last   <= (cnt == ADDR_W'(1));
          end
        end
        DRAIN: begin
          if (tail_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path: valid, owner and last flag ride ROM_LAT cycles behind each read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].vld  <= rom_en_q;
      pipe[0].last <= rom_en_q & rom_last;
      pipe[0].id   <= rom_en_q ? owner : '0;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign bus.grant    = grant_q;
  assign bus.busy     = (grant_q != '0) || (state != IDLE);
  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rd_valid = tail.vld;
  assign bus.rd_id    = tail.id;
  assign bus.rd_data  = tail.vld ? bus.rom_data : {DATA_W{1'b0}};
  assign bus.done     = tail_done;

endmodule
